mult_coe_ctrl: RTL and testbench
================================

# mult_coe_ctrl

Coefficient controller for the per-channel RGB gain multiplier in the video filter chain. Accepts coefficient writes from the register interface into staging registers. On a commit, it applies them to the multiplier's coefficient bus only at frame boundaries (rising edge of `vs_i`), so a frame never mixes old and new gains. It can apply the new values at once, or ramp them toward the target by a bounded step per frame to avoid visible flicker.

## Interface
- `COE_WIDTH`, 16, coefficient width; unsigned fixed point, 0x0400 = 1.000
- `COE_COUNT`, 3, number of channels (R, G, B)
- `COE_RAMP_STEP`, 16, maximum per-frame change of one coefficient in ramp mode; must be ≥ 1
- `COE_DEFAULT`, 16'h0400, reset value of every coefficient

- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-low
- `wr_en_i`  in  1  write strobe for a staging register
- `wr_addr_i`  in  2  channel index; values ≥ `COE_COUNT` are ignored
- `wr_data_i`  in  COE_WIDTH  staging value
- `commit_i`  in  1  one-cycle pulse; copies staging into target and arms an update
- `ramp_en_i`  in  1  0 = jump to target, 1 = ramp to target; sampled at each applied `vs_i` edge
- `vs_i`  in  1  vertical sync, same signal that feeds the multiplier
- `coe_o`  out  COE_WIDTH*COE_COUNT  channel k at `[k*COE_WIDTH +: COE_WIDTH]`, registered
- `busy_o`  out  1  high while an update is pending or ramping
- `upd_o`  out  1  one-cycle pulse in the cycle `coe_o` takes a new value

## Operation
- Registers per channel:
  - `stg[k]`: staging, written by `wr_en_i`
  - `tgt[k]`: target, loaded by `commit_i`
  - `cur[k]`: current value, drives `coe_o`
- Write and commit in the same cycle: the commit copies the pre-write staging value. The write lands in staging only.
- Edge detection: `vs_d` holds the previous `vs_i`. `edge = vs_i & ~vs_d`.
- State `IDLE`:
  - `commit_i` moves the block to `ARMED`.
  - `edge` is ignored.
- State `ARMED`, on `edge`:
  - If `ramp_en_i` = 0: `cur[k] <= tgt[k]` for all k, then go to `IDLE`.
  - If `ramp_en_i` = 1: apply one ramp step (below). Go to `IDLE` if all channels now equal target, otherwise go to `RAMP`.
- State `RAMP`, on `edge`:
  - Apply one ramp step, or jump to target if `ramp_en_i` has dropped to 0.
  - Go to `IDLE` when `cur == tgt` for all channels.
- Ramp step, per channel:
  - If `cur < tgt`: `cur += min(STEP, tgt - cur)`.
  - If `cur > tgt`: `cur -= min(STEP, cur - tgt)`.
  - If equal: unchanged.
  - Differences are computed unsigned at COE_WIDTH+1 bits. Values never overshoot or wrap.
- Commit while `ARMED` or `RAMP`:
  - `tgt` is replaced.
  - The state becomes or stays `ARMED`, or `RAMP` if already ramping.
  - Ramping continues from the present `cur`.
- `commit_i` and `edge` in the same cycle: the edge is processed against the old state and old target. The new target takes effect from the next edge. If the old state was `IDLE`, the block is `ARMED` afterwards.
- A commit whose target equals `cur` still arms. The next edge completes immediately, with `upd_o` asserted.
- `busy_o` = (state != `IDLE`).
- `upd_o` pulses on every applied edge: a jump, a step, or the completing step.

## Timing
- `edge` seen in cycle N → `coe_o` new value and `upd_o` = 1 in cycle N+1. `busy_o` falls in N+1 on completion.
- `commit_i` in cycle N → `busy_o` = 1 in N+1.
- Writes are visible in staging at N+1. A commit in N+1 captures them.
- Reset (`rst` = 0 at a clock edge):
  - `cur`, `tgt` and `stg` all become `COE_DEFAULT`; `coe_o` reads `COE_DEFAULT` per channel.
  - `busy_o` = 0, `upd_o` = 0, `vs_d` = 0, state `IDLE`.
- Reset mid-ramp aborts the ramp. Outputs return to the reset values on the next edge.
- After reset with `vs_i` already high, the first cycle may detect an edge. It is harmless because the state is `IDLE`.
- Maximum ramp length is ceil(max |tgt - cur| / STEP) frames.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles → `coe_o` = {0x0400, 0x0400, 0x0400}, `busy_o` = 0, `upd_o` = 0.
- **Jump mode:** write ch0 = 0x0600, ch2 = 0x0200, commit, `ramp_en_i` = 0, then `vs_i` rising → `coe_o` unchanged until edge cycle +1. It then becomes {0x0600, 0x0400, 0x0200} with one `upd_o` pulse and `busy_o` falling.
- **Ramp mode:** STEP = 16, target ch1 = 0x0428 from 0x0400, `ramp_en_i` = 1 → ch1 reads 0x0410, 0x0420, 0x0428 on three successive frames. Three `upd_o` pulses; `busy_o` clears after the third.
- **Downward ramp with retarget:** ramping ch0 0x0400 → 0x0300, commit 0x0420 after two frames (ch0 = 0x03E0) → the next edges give 0x03F0, 0x0400, 0x0410, 0x0420.
- **Same-cycle events:**
  - Commit coincident with a `vs_i` edge while `IDLE` → no change at that edge; applied at the following edge.
  - `wr_en_i` + `commit_i` in the same cycle → the old staging value is committed.
  - `wr_addr_i` = 3 → ignored.
- **Reset mid-ramp:** pulse `rst` low for 1 cycle during `RAMP` → defaults restored, `IDLE`, and later `vs_i` edges cause no `upd_o`.

Source files
------------

// File: rtl/mult_coe_ctrl_if.sv
// Register-side and multiplier-side signals of the RGB gain coefficient controller.
// The master modport belongs to the register/sync driver and the slave modport to the controller.
interface mult_coe_ctrl_if #(
  parameter int unsigned COE_WIDTH = 16,
  parameter int unsigned COE_COUNT = 3
);
  logic                           wr_en_i;
  logic [1:0]                     wr_addr_i;
  logic [COE_WIDTH-1:0]           wr_data_i;
  logic                           commit_i;
  logic                           ramp_en_i;
  logic                           vs_i;
  logic [COE_WIDTH*COE_COUNT-1:0] coe_o;
  logic                           busy_o;
  logic                           upd_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, commit_i, ramp_en_i, vs_i,
    input  coe_o, busy_o, upd_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, commit_i, ramp_en_i, vs_i,
    output coe_o, busy_o, upd_o
  );
endinterface

// File: rtl/mult_coe_ctrl.sv
// Stages per-channel gain coefficients and applies committed values only on vs rising edges,
// either as a single jump or as a bounded per-frame ramp toward the target.
module mult_coe_ctrl #(
  parameter int unsigned          COE_WIDTH     = 16,
  parameter int unsigned          COE_COUNT     = 3,
  parameter int unsigned          COE_RAMP_STEP = 16,
  parameter logic [COE_WIDTH-1:0] COE_DEFAULT   = 16'h0400
) (
  input logic           clk,
  input logic           rst,
  mult_coe_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RAMP  = 2'd2;

  localparam logic [COE_WIDTH:0] STEP_W = COE_RAMP_STEP[COE_WIDTH:0];

  logic [COE_WIDTH-1:0] stg_r     [COE_COUNT];
  logic [COE_WIDTH-1:0] tgt_r     [COE_COUNT];
  logic [COE_WIDTH-1:0] cur_r     [COE_COUNT];
  logic [COE_WIDTH-1:0] cur_nxt_s [COE_COUNT];

  logic [1:0] state_r;
  logic [1:0] edge_state_s;
  logic [1:0] state_nxt_s;
  logic       vs_d_r;
  logic       edge_s;
  logic       all_eq_s;
  logic       upd_nxt_s;
  logic       upd_r;
  logic       busy_r;

  // One ramp step: move toward tgt by at most STEP_W, never past it (extra bit prevents wrap).
  function automatic logic [COE_WIDTH-1:0] ramp_step(
    input logic [COE_WIDTH-1:0] cur,
    input logic [COE_WIDTH-1:0] tgt
  );
    logic [COE_WIDTH:0] cur_x;
    logic [COE_WIDTH:0] tgt_x;
    logic [COE_WIDTH:0] res_x;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    if (cur_x < tgt_x) begin
      if ((tgt_x - cur_x) > STEP_W) res_x = cur_x + STEP_W;
      else                          res_x = tgt_x;
    end else if (cur_x > tgt_x) begin
      if ((cur_x - tgt_x) > STEP_W) res_x = cur_x - STEP_W;
      else                          res_x = tgt_x;
    end else begin
      res_x = cur_x;
    end
    return res_x[COE_WIDTH-1:0];
  endfunction

  assign edge_s = bus.vs_i & ~vs_d_r;

  // Edge processing uses the pre-commit state/target; a commit then overrides the next state.
  always_comb begin
    edge_state_s = state_r;
    upd_nxt_s    = 1'b0;
    all_eq_s     = 1'b1;
    for (int k = 0; k < int'(COE_COUNT); k++) begin
      cur_nxt_s[k] = cur_r[k];
    end
    case (state_r)
      ST_IDLE: begin
        edge_state_s = ST_IDLE;
      end
      ST_ARMED, ST_RAMP: begin
        if (edge_s) begin
          upd_nxt_s = 1'b1;
          for (int k = 0; k < int'(COE_COUNT); k++) begin
            if (bus.ramp_en_i) cur_nxt_s[k] = ramp_step(cur_r[k], tgt_r[k]);
            else               cur_nxt_s[k] = tgt_r[k];
            if (cur_nxt_s[k] != tgt_r[k]) all_eq_s = 1'b0;
            else                          all_eq_s = all_eq_s;
          end
          if (all_eq_s) edge_state_s = ST_IDLE;
          else          edge_state_s = ST_RAMP;
        end else begin
          edge_state_s = state_r;
        end
      end
      default: begin
        edge_state_s = ST_IDLE;
      end
    endcase
    if (bus.commit_i) begin
      if (edge_state_s == ST_RAMP) state_nxt_s = ST_RAMP;
      else                         state_nxt_s = ST_ARMED;
    end else begin
      state_nxt_s = edge_state_s;
    end
  end

  // Control state, sync-edge history and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      vs_d_r  <= 1'b0;
      busy_r  <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      vs_d_r  <= bus.vs_i;
      busy_r  <= (state_nxt_s != ST_IDLE);
      upd_r   <= upd_nxt_s;
    end
  end

  // Coefficient storage; commit copies staging as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(COE_COUNT); k++) begin
        stg_r[k] <= COE_DEFAULT;
        tgt_r[k] <= COE_DEFAULT;
        cur_r[k] <= COE_DEFAULT;
      end
    end else begin
      for (int k = 0; k < int'(COE_COUNT); k++) begin
        cur_r[k] <= cur_nxt_s[k];
        if (bus.commit_i) tgt_r[k] <= stg_r[k];
        if (bus.wr_en_i && (bus.wr_addr_i == 2'(k))) stg_r[k] <= bus.wr_data_i;
      end
    end
  end

  for (genvar g = 0; g < int'(COE_COUNT); g++) begin : g_out
    assign bus.coe_o[g*COE_WIDTH +: COE_WIDTH] = cur_r[g];
  end

  assign bus.busy_o = busy_r;
  assign bus.upd_o  = upd_r;

endmodule

// File: tb/tb_mult_coe_ctrl.sv
// Directed table-driven bench for mult_coe_ctrl: one row per cycle, expected outputs
// hand-computed, plus a hand-written reset-during-ramp sequence.
module tb_mult_coe_ctrl;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic        ramp;
    logic        vs;
    logic [47:0] coe;
    logic        busy;
    logic        upd;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vecs[$];

  mult_coe_ctrl_if bus ();

  mult_coe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] c3(input logic [15:0] ch0, input logic [15:0] ch1,
                                     input logic [15:0] ch2);
    return {ch2, ch1, ch0};
  endfunction

  task automatic add(input logic we, input logic [1:0] addr, input logic [15:0] data,
                     input logic commit, input logic ramp, input logic vs,
                     input logic [47:0] coe, input logic busy, input logic upd);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.commit = commit; v.ramp = ramp;
    v.vs = vs; v.coe = coe; v.busy = busy; v.upd = upd;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [47:0] act,
                       input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [47:0] coe,
                           input logic busy, input logic upd);
    check({tag, ".coe"},  idx, bus.coe_o, coe);
    check({tag, ".busy"}, idx, {47'd0, bus.busy_o}, {47'd0, busy});
    check({tag, ".upd"},  idx, {47'd0, bus.upd_o}, {47'd0, upd});
  endtask

  task automatic drive(input logic we, input logic [1:0] addr, input logic [15:0] data,
                       input logic commit, input logic ramp, input logic vs);
    bus.wr_en_i   = we;
    bus.wr_addr_i = addr;
    bus.wr_data_i = data;
    bus.commit_i  = commit;
    bus.ramp_en_i = ramp;
    bus.vs_i      = vs;
  endtask

  initial begin
    logic [47:0] dflt;
    tests = 0;
    fails = 0;
    dflt  = c3(16'h0400, 16'h0400, 16'h0400);

    // jump mode
    add(1'b1, 2'd0, 16'h0600, 1'b0, 1'b0, 1'b0, dflt, 1'b0, 1'b0);
    add(1'b1, 2'd2, 16'h0200, 1'b0, 1'b0, 1'b0, dflt, 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, dflt, 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, dflt, 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0600, 16'h0400, 16'h0200), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0600, 16'h0400, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0600, 16'h0400, 16'h0200), 1'b0, 1'b0);
    // upward ramp of ch1 to 0x0428
    add(1'b1, 2'd1, 16'h0428, 1'b0, 1'b1, 1'b0, c3(16'h0600, 16'h0400, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, c3(16'h0600, 16'h0400, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0600, 16'h0410, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0600, 16'h0410, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0600, 16'h0420, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0600, 16'h0420, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0600, 16'h0428, 16'h0200), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0600, 16'h0428, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0600, 16'h0428, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0600, 16'h0428, 16'h0200), 1'b0, 1'b0);
    // bring ch0 to 0x0400 by jump
    add(1'b1, 2'd0, 16'h0400, 1'b0, 1'b0, 1'b0, c3(16'h0600, 16'h0428, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, c3(16'h0600, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0400, 16'h0428, 16'h0200), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0400, 16'h0428, 16'h0200), 1'b0, 1'b0);
    // downward ramp to 0x0300, retarget to 0x0420 after two frames
    add(1'b1, 2'd0, 16'h0300, 1'b0, 1'b1, 1'b0, c3(16'h0400, 16'h0428, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, c3(16'h0400, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h03F0, 16'h0428, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h03F0, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h03E0, 16'h0428, 16'h0200), 1'b1, 1'b1);
    add(1'b1, 2'd0, 16'h0420, 1'b0, 1'b1, 1'b0, c3(16'h03E0, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, c3(16'h03E0, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h03F0, 16'h0428, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h03F0, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0400, 16'h0428, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0400, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0410, 16'h0428, 16'h0200), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0410, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0420, 16'h0428, 16'h0200), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, c3(16'h0420, 16'h0428, 16'h0200), 1'b0, 1'b0);
    // commit coincident with an edge while idle: applied on the following edge
    add(1'b1, 2'd2, 16'h0300, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0200), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, c3(16'h0420, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0200), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0420, 16'h0428, 16'h0300), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0300), 1'b0, 1'b0);
    // write+commit together commits old staging (equal to cur, still pulses upd)
    add(1'b1, 2'd1, 16'h0500, 1'b1, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0300), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0420, 16'h0428, 16'h0300), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0300), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, c3(16'h0420, 16'h0428, 16'h0300), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b0);
    // out-of-range address is ignored
    add(1'b1, 2'd3, 16'h1234, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b0);
    // ramp_en dropping mid-ramp jumps straight to target
    add(1'b1, 2'd2, 16'h0100, 1'b0, 1'b1, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b0, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, c3(16'h0420, 16'h0500, 16'h0300), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, c3(16'h0420, 16'h0500, 16'h02F0), 1'b1, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h02F0), 1'b1, 1'b0);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, c3(16'h0420, 16'h0500, 16'h0100), 1'b0, 1'b1);
    add(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, c3(16'h0420, 16'h0500, 16'h0100), 1'b0, 1'b0);

    // reset for three cycles
    rst = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_all("reset", 0, dflt, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].commit, vecs[i].ramp, vecs[i].vs);
      tick();
      check_all("vec", i, vecs[i].coe, vecs[i].busy, vecs[i].upd);
    end

    // reset pulse during a downward ramp of ch0 from 0x0420 toward 0x0000
    drive(1'b1, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("midramp_arm", 0, c3(16'h0420, 16'h0500, 16'h0100), 1'b1, 1'b0);
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_all("midramp_step", 0, c3(16'h0410, 16'h0500, 16'h0100), 1'b1, 1'b1);
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_all("midramp_rst", 0, dflt, 1'b0, 1'b0);
    rst = 1'b1;
    for (int f = 0; f < 3; f++) begin
      drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
      tick();
      check_all("post_rst_edge", f, dflt, 1'b0, 1'b0);
      drive(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
